rv32i_axil_master_bridge: RTL and testbench

- Sits directly downstream of the RV32I core's memory-access stage. It consumes the core's external (MMIO) load/store requests and runs them as single AXI4-Lite transactions.
- Holds the pipeline stalled while a transaction is in flight.
- Returns load data, with its destination register, to the core's register-file write port.
- Handles byte/halfword lane steering, sign/zero extension, misalignment and bus timeout.

---
 rtl/rv32i_axil_master_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_rv32i_axil_master_bridge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_axil_master_bridge.sv
// Bridges RV32I memory-stage MMIO loads/stores onto a single-outstanding AXI4-Lite master.
// The core is stalled for the whole transaction. Load results return through a one-cycle DONE writeback pulse.
`timescale 1ns/1ps
module rv32i_axil_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_init_i,
  input  logic        core_mem_we_i,
  input  logic [2:0]  core_funct3_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_data_w_i,
  input  logic        core_reg_we_i,
  input  logic [4:0]  core_addr_d_i,
  output logic        core_stall_o,
  output logic        core_reg_we_o,
  output logic [4:0]  core_addr_d_o,
  output logic [31:0] core_data_d_o,
  output logic        err_o,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d, rwe_q, rwe_d, err_q, err_d, reg_we_q, reg_we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    alo_q, alo_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   awaddr_q, awaddr_d, araddr_q, araddr_d, wdata_q, wdata_d, data_q, data_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic          arvalid_q, arvalid_d, rready_q, rready_d;
  logic          hs_s, busy_s, timeout_s, aw_done_s, w_done_s, misal_s, load_wb_s;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1] && a != 2'b00);
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_strb = 4'b0001 << a;
      2'b01:   store_strb = 4'b0011 << {a[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {24'h00_0000, sh[7:0]};
      3'b101:  load_ext = {16'h0000, sh[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d   = state_q;   cnt_d     = cnt_q;     we_d      = we_q;     rwe_d    = rwe_q;
    err_d     = err_q;     reg_we_d  = 1'b0;      f3_d      = f3_q;     alo_d    = alo_q;
    rd_d      = rd_q;      awaddr_d  = awaddr_q;  araddr_d  = araddr_q; wdata_d  = wdata_q;
    data_d    = data_q;    wstrb_d   = wstrb_q;   awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;  bready_d  = bready_q;  arvalid_d = arvalid_q; rready_d = rready_q;

    hs_s = (awvalid_q & m_awready) | (wvalid_q & m_wready) | (bready_q & m_bvalid)
         | (arvalid_q & m_arready) | (rready_q & m_rvalid);
    busy_s    = (state_q == S_WRITE) || (state_q == S_WRESP) || (state_q == S_RADDR) || (state_q == S_RDATA);
    timeout_s = busy_s && !hs_s && (cnt_q == CNT_LAST);
    aw_done_s = !awvalid_q || m_awready;
    w_done_s  = !wvalid_q || m_wready;
    misal_s   = misaligned(core_funct3_i, core_addr_i[1:0]);
    load_wb_s = !we_q && rwe_q && (rd_q != 5'd0);

    if (busy_s && !hs_s) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CW{1'b0}};
    end

    if (timeout_s) begin
      // Abandon the bus cleanly and report the failure to the core as an error load.
      awvalid_d = 1'b0; wvalid_d = 1'b0; bready_d = 1'b0; arvalid_d = 1'b0; rready_d = 1'b0;
      err_d     = 1'b1;
      data_d    = ERR_RDATA;
      reg_we_d  = load_wb_s;
      state_d   = S_DONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (core_init_i) begin
            we_d  = core_mem_we_i;
            f3_d  = core_funct3_i;
            alo_d = core_addr_i[1:0];
            rd_d  = core_addr_d_i;
            rwe_d = core_reg_we_i;
            if (misal_s) begin
              err_d    = 1'b1;
              data_d   = ERR_RDATA;
              reg_we_d = !core_mem_we_i && core_reg_we_i && (core_addr_d_i != 5'd0);
              state_d  = S_DONE;
            end else if (core_mem_we_i) begin
              awaddr_d  = {core_addr_i[31:2], 2'b00};
              wdata_d   = store_data(core_funct3_i, core_data_w_i);
              wstrb_d   = store_strb(core_funct3_i, core_addr_i[1:0]);
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              state_d   = S_WRITE;
            end else begin
              araddr_d  = {core_addr_i[31:2], 2'b00};
              arvalid_d = 1'b1;
              state_d   = S_RADDR;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WRITE: begin
          if (awvalid_q && m_awready) awvalid_d = 1'b0; else awvalid_d = awvalid_q;
          if (wvalid_q && m_wready) wvalid_d = 1'b0; else wvalid_d = wvalid_q;
          if (aw_done_s && w_done_s) begin
            bready_d = 1'b1;
            state_d  = S_WRESP;
          end else begin
            state_d = S_WRITE;
          end
        end
        S_WRESP: begin
          if (m_bvalid) begin
            bready_d = 1'b0;
            err_d    = err_q | (m_bresp != 2'b00);
            state_d  = S_DONE;
          end else begin
            state_d = S_WRESP;
          end
        end
        S_RADDR: begin
          if (m_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = S_RDATA;
          end else begin
            state_d = S_RADDR;
          end
        end
        S_RDATA: begin
          if (m_rvalid) begin
            rready_d = 1'b0;
            data_d   = load_ext(f3_q, alo_q, m_rdata);
            err_d    = err_q | (m_rresp != 2'b00);
            reg_we_d = load_wb_s;
            state_d  = S_DONE;
          end else begin
            state_d = S_RDATA;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;  cnt_q    <= {CW{1'b0}};
      we_q      <= 1'b0;    rwe_q    <= 1'b0;   err_q    <= 1'b0;  reg_we_q <= 1'b0;
      f3_q      <= 3'b000;  alo_q    <= 2'b00;  rd_q     <= 5'd0;
      awaddr_q  <= 32'h0;   araddr_q <= 32'h0;  wdata_q  <= 32'h0; data_q   <= 32'h0;
      wstrb_q   <= 4'h0;    awvalid_q <= 1'b0;  wvalid_q <= 1'b0;  bready_q <= 1'b0;
      arvalid_q <= 1'b0;    rready_q <= 1'b0;
    end else begin
      state_q   <= state_d;   cnt_q    <= cnt_d;
      we_q      <= we_d;      rwe_q    <= rwe_d;    err_q    <= err_d;   reg_we_q <= reg_we_d;
      f3_q      <= f3_d;      alo_q    <= alo_d;    rd_q     <= rd_d;
      awaddr_q  <= awaddr_d;  araddr_q <= araddr_d; wdata_q  <= wdata_d; data_q   <= data_d;
      wstrb_q   <= wstrb_d;   awvalid_q <= awvalid_d; wvalid_q <= wvalid_d; bready_q <= bready_d;
      arvalid_q <= arvalid_d; rready_q <= rready_d;
    end
  end

  assign core_stall_o  = ((state_q != S_IDLE) && (state_q != S_DONE)) || ((state_q == S_IDLE) && core_init_i);
  assign core_reg_we_o = reg_we_q;
  assign core_addr_d_o = rd_q;
  assign core_data_d_o = data_q;
  assign err_o         = err_q;
  assign m_awaddr      = awaddr_q;
  assign m_awvalid     = awvalid_q;
  assign m_wdata       = wdata_q;
  assign m_wstrb       = wstrb_q;
  assign m_wvalid      = wvalid_q;
  assign m_bready      = bready_q;
  assign m_araddr      = araddr_q;
  assign m_arvalid     = arvalid_q;
  assign m_rready      = rready_q;

endmodule

// File: tb/tb_rv32i_axil_master_bridge.sv
// Table-driven bench for rv32i_axil_master_bridge with a configurable-latency AXI4-Lite slave model.
`timescale 1ns/1ps
module tb_rv32i_axil_master_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_init_i = 1'b0, core_mem_we_i = 1'b0, core_reg_we_i = 1'b0;
  logic [2:0] core_funct3_i = 3'b000;
  logic [31:0] core_addr_i = 32'h0, core_data_w_i = 32'h0;
  logic [4:0] core_addr_d_i = 5'd0;
  logic core_stall_o, core_reg_we_o, err_o;
  logic [4:0] core_addr_d_o;
  logic [31:0] core_data_d_o;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0] m_wstrb;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0] m_bresp, m_rresp;

  // slave configuration, driven by the stimulus process
  int aw_dly = 0, w_dly = 0;
  logic ar_never = 1'b0, r_hold = 1'b0;
  logic [1:0] sl_resp = 2'b00;
  logic [31:0] sl_rdata = 32'h0;

  // slave state and monitors
  int aw_wait, w_wait, avc, wvc;
  logic aw_got, w_got, b_pend, r_pend;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0] cap_wstrb;

  int n_tests = 0, n_fail = 0;

  rv32i_axil_master_bridge #(.TIMEOUT_CYCLES(16), .ERR_RDATA(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_init_i(core_init_i), .core_mem_we_i(core_mem_we_i), .core_funct3_i(core_funct3_i),
    .core_addr_i(core_addr_i), .core_data_w_i(core_data_w_i), .core_reg_we_i(core_reg_we_i),
    .core_addr_d_i(core_addr_d_i), .core_stall_o(core_stall_o), .core_reg_we_o(core_reg_we_o),
    .core_addr_d_o(core_addr_d_o), .core_data_d_o(core_data_d_o), .err_o(err_o),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  assign m_awready = m_awvalid && (aw_wait >= aw_dly);
  assign m_wready  = m_wvalid && (w_wait >= w_dly);
  assign m_arready = m_arvalid && !ar_never;
  assign m_bvalid  = b_pend;
  assign m_bresp   = sl_resp;
  assign m_rvalid  = r_pend && !r_hold;
  assign m_rresp   = sl_resp;
  assign m_rdata   = sl_rdata;

  // Slave handshakes, response generation and bus monitors.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; avc <= 0; wvc <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      cap_awaddr <= 32'h0; cap_wdata <= 32'h0; cap_araddr <= 32'h0; cap_wstrb <= 4'h0;
    end else begin
      aw_wait <= (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_wvalid && !m_wready) ? w_wait + 1 : 0;
      if (m_awvalid || m_arvalid) avc <= avc + 1;
      if (m_wvalid) wvc <= wvc + 1;
      if (m_awvalid && m_awready) cap_awaddr <= m_awaddr;
      if (m_wvalid && m_wready) begin cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; end
      if (m_bvalid && m_bready) b_pend <= 1'b0;
      if ((aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready))) begin
        b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (m_awvalid && m_awready) aw_got <= 1'b1;
        if (m_wvalid && m_wready) w_got <= 1'b1;
      end
      if (m_arvalid && m_arready) begin r_pend <= 1'b1; cap_araddr <= m_araddr; end
      if (m_rvalid && m_rready) r_pend <= 1'b0;
    end
  end

  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata; logic [4:0] rd; logic regwe;
    logic [31:0] rdata; logic [1:0] resp; int aw_dly; int w_dly; logic ar_never;
    logic [31:0] exp_addr; logic [3:0] exp_strb; logic [31:0] exp_wdata;
    int exp_stall; int exp_avc; int exp_wvc; logic exp_we; logic [31:0] exp_data; logic exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int stall_n, n;
    v = vecs[i];
    aw_dly = v.aw_dly; w_dly = v.w_dly; ar_never = v.ar_never; sl_resp = v.resp; sl_rdata = v.rdata;
    do_reset();
    core_init_i = 1'b1; core_mem_we_i = v.we; core_funct3_i = v.f3; core_addr_i = v.addr;
    core_data_w_i = v.wdata; core_addr_d_i = v.rd; core_reg_we_i = v.regwe;
    #1;
    stall_n = core_stall_o ? 1 : 0;
    @(negedge clk);
    core_init_i = 1'b0;
    n = 0;
    #1;
    while (core_stall_o && n < 200) begin
      stall_n++; n++;
      @(negedge clk); #1;
    end
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d_done_wait: got no completion, expected one within 200 cycles", i);
    end
    chk($sformatf("v%0d_stall_cycles", i), 32'(stall_n), 32'(v.exp_stall));
    chk($sformatf("v%0d_addr_valid_cycles", i), 32'(avc), 32'(v.exp_avc));
    chk($sformatf("v%0d_wvalid_cycles", i), 32'(wvc), 32'(v.exp_wvc));
    if (v.exp_avc != 0 && !v.ar_never)
      chk($sformatf("v%0d_bus_addr", i), v.we ? cap_awaddr : cap_araddr, v.exp_addr);
    if (v.we && v.exp_avc != 0) begin
      chk($sformatf("v%0d_wstrb", i), {28'h0, cap_wstrb}, {28'h0, v.exp_strb});
      chk($sformatf("v%0d_wdata", i), cap_wdata, v.exp_wdata);
    end
    chk($sformatf("v%0d_reg_we", i), {31'h0, core_reg_we_o}, {31'h0, v.exp_we});
    if (v.exp_we) begin
      chk($sformatf("v%0d_addr_d", i), {27'h0, core_addr_d_o}, {27'h0, v.rd});
      chk($sformatf("v%0d_data_d", i), core_data_d_o, v.exp_data);
    end
    chk($sformatf("v%0d_err", i), {31'h0, err_o}, {31'h0, v.exp_err});
    @(negedge clk); #1;
    chk($sformatf("v%0d_pulse_end", i), {30'h0, core_reg_we_o, core_stall_o}, 32'h0);
  endtask

  initial begin
    int we_seen;
    //          we    f3      addr          wdata         rd     rwe   rdata         resp   awd wd arn   exp_addr      strb     exp_wdata     st avc wvc ewe   exp_data      eerr
    vecs[0]  = '{1'b1, 3'b010, 32'h4000_0008, 32'h1234_5678, 5'd3, 1'b1, 32'h0,        2'b00, 0, 0, 1'b0, 32'h4000_0008, 4'hF,    32'h1234_5678, 3, 1,  1,  1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 3'b000, 32'h4000_0003, 32'h0000_00A5, 5'd0, 1'b0, 32'h0,        2'b00, 0, 0, 1'b0, 32'h4000_0000, 4'b1000, 32'hA5A5_A5A5, 3, 1,  1,  1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 3'b000, 32'h4000_0003, 32'h0,         5'd5, 1'b1, 32'h80FF_FF00, 2'b00, 0, 0, 1'b0, 32'h4000_0000, 4'h0,    32'h0,         3, 1,  0,  1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[3]  = '{1'b0, 3'b100, 32'h4000_0003, 32'h0,         5'd5, 1'b1, 32'h80FF_FF00, 2'b00, 0, 0, 1'b0, 32'h4000_0000, 4'h0,    32'h0,         3, 1,  0,  1'b1, 32'h0000_0080, 1'b0};
    vecs[4]  = '{1'b0, 3'b001, 32'h4000_0012, 32'h0,         5'd6, 1'b1, 32'h8001_1234, 2'b00, 0, 0, 1'b0, 32'h4000_0010, 4'h0,    32'h0,         3, 1,  0,  1'b1, 32'hFFFF_8001, 1'b0};
    vecs[5]  = '{1'b0, 3'b101, 32'h4000_0012, 32'h0,         5'd6, 1'b1, 32'h8001_1234, 2'b00, 0, 0, 1'b0, 32'h4000_0010, 4'h0,    32'h0,         3, 1,  0,  1'b1, 32'h0000_8001, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 32'h4000_0004, 32'h0,         5'd31, 1'b1, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0, 32'h4000_0004, 4'h0,   32'h0,         3, 1,  0,  1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{1'b0, 3'b010, 32'h4000_0004, 32'h0,         5'd0, 1'b1, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0, 32'h4000_0004, 4'h0,    32'h0,         3, 1,  0,  1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 3'b001, 32'h4000_0002, 32'h0000_BEEF, 5'd0, 1'b0, 32'h0,        2'b10, 0, 4, 1'b0, 32'h4000_0000, 4'b1100, 32'hBEEF_BEEF, 7, 1,  5,  1'b0, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 3'b010, 32'h4000_0020, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0,        2'b00, 2, 0, 1'b0, 32'h4000_0020, 4'hF,    32'hCAFE_F00D, 5, 3,  1,  1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 3'b001, 32'h4000_0000, 32'h0,         5'd4, 1'b1, 32'h0000_7FFF, 2'b10, 0, 0, 1'b0, 32'h4000_0000, 4'h0,    32'h0,         3, 1,  0,  1'b1, 32'h0000_7FFF, 1'b1};
    vecs[11] = '{1'b0, 3'b010, 32'h4000_0002, 32'h0,         5'd7, 1'b1, 32'h1111_1111, 2'b00, 0, 0, 1'b0, 32'h0,        4'h0,    32'h0,         1, 0,  0,  1'b1, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 3'b010, 32'h4000_0010, 32'h0,         5'd9, 1'b1, 32'h2222_2222, 2'b00, 0, 0, 1'b1, 32'h0,        4'h0,    32'h0,         17, 16, 0, 1'b1, 32'h0,        1'b1};

    // reset state
    @(negedge clk); #1;
    chk("rst_stall_we_err", {29'h0, core_stall_o, core_reg_we_o, err_o}, 32'h0);
    chk("rst_valids", {27'h0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 32'h0);
    chk("rst_awaddr", m_awaddr, 32'h0);
    chk("rst_araddr", m_araddr, 32'h0);
    chk("rst_data_d", core_data_d_o, 32'h0);
    chk("rst_addr_d", {27'h0, core_addr_d_o}, 32'h0);

    for (int i = 0; i < 13; i++) run_vec(i);

    // reset in RDATA abandons the load without a writeback pulse
    aw_dly = 0; w_dly = 0; ar_never = 1'b0; sl_resp = 2'b00; sl_rdata = 32'h1234_5678;
    do_reset();
    r_hold = 1'b1;
    core_init_i = 1'b1; core_mem_we_i = 1'b0; core_funct3_i = 3'b010; core_addr_i = 32'h4000_0000;
    core_reg_we_i = 1'b1; core_addr_d_i = 5'd3;
    @(negedge clk); core_init_i = 1'b0;
    @(negedge clk); #1;
    chk("rs_in_rdata", {30'h0, m_rready, core_stall_o}, 32'h3);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rs_outputs", {26'h0, m_rready, m_arvalid, m_awvalid, core_stall_o, core_reg_we_o, err_o}, 32'h0);
    chk("rs_data_addr_d", core_data_d_o | {27'h0, core_addr_d_o}, 32'h0);
    rst_n = 1'b1; r_hold = 1'b0;
    we_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (core_reg_we_o || core_stall_o) we_seen++;
    end
    chk("rs_no_pulse", 32'(we_seen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
